// File: rtl/accelerator_config_pkg.sv
// ---------------------------------------------------------------------------
// accelerator_config_pkg
// Shared sizing constants for the accelerator datapath blocks.
//   TILE_WIDTH : bits carried by one tile on a tile bus
//   DATA_WIDTH : bits per element inside a tile
// ---------------------------------------------------------------------------
package accelerator_config_pkg;
  localparam int TILE_WIDTH = 32;
  localparam int DATA_WIDTH = 8;
endpackage

// File: rtl/store_v.sv
// ---------------------------------------------------------------------------
// store_v
// Streams tiles from a producer out to memory one element per cycle.
// A start pulse latches a base element address and an element count; the
// block then repeatedly accepts a tile (E = TILE_WIDTH/DATA_WIDTH elements),
// buffers it, and writes its elements to consecutive addresses until the
// count is exhausted. A partial final tile writes only the remaining
// elements. valid_out pulses for one cycle when the transfer completes.
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   synchronous active-high reset
//   valid_in    in   start pulse, sampled only while idle
//   dram_addr   in   [23:0] base element address, sampled with valid_in
//   length      in   [9:0]  element count, sampled with valid_in
//   tile_in     in   [DATA_WIDTH-1:0] x [0:E-1] tile elements
//   tile_valid  in   producer presents a tile
//   tile_ready  out  block accepts a tile this cycle
//   mem_we      out  memory write enable
//   mem_addr    out  [23:0] memory write address
//   mem_din     out  [DATA_WIDTH-1:0] memory write data
//   busy        out  high whenever a transfer is in progress
//   valid_out   out  one-cycle completion pulse
// ---------------------------------------------------------------------------
module store_v #(
  parameter int TILE_WIDTH = accelerator_config_pkg::TILE_WIDTH,
  parameter int DATA_WIDTH = accelerator_config_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic [23:0]           dram_addr,
  input  logic [9:0]            length,
  input  logic [DATA_WIDTH-1:0] tile_in [0:TILE_WIDTH/DATA_WIDTH-1],
  input  logic                  tile_valid,
  output logic                  tile_ready,
  output logic                  mem_we,
  output logic [23:0]           mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  output logic                  busy,
  output logic                  valid_out
);

  localparam int E     = TILE_WIDTH / DATA_WIDTH;
  localparam int IDX_W = $clog2(E);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_WAIT_TILE = 2'd1;
  localparam logic [1:0] S_WRITING   = 2'd2;
  localparam logic [1:0] S_DONE      = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [23:0]           addr_q,  addr_d;
  logic [9:0]            rem_q,   rem_d;
  logic [IDX_W-1:0]      idx_q,   idx_d;
  logic [DATA_WIDTH-1:0] buf_q [0:E-1];
  logic [DATA_WIDTH-1:0] buf_d [0:E-1];

  // Outputs decode straight from registered state so they carry no input paths.
  assign busy       = (state_q != S_IDLE);
  assign tile_ready = (state_q == S_WAIT_TILE);
  assign mem_we     = (state_q == S_WRITING);
  assign valid_out  = (state_q == S_DONE);
  assign mem_addr   = addr_q;
  assign mem_din    = buf_q[idx_q];

  // Next-state and datapath update for the transfer sequencer.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    case (state_q)
      S_IDLE: begin
        if (valid_in) begin
          addr_d  = dram_addr;
          rem_d   = length;
          state_d = (length != 10'd0) ? S_WAIT_TILE : S_DONE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT_TILE: begin
        if (tile_valid) begin
          // Snapshot the whole tile so later tile_in changes cannot leak in.
          for (int i = 0; i < E; i++) begin
            buf_d[i] = tile_in[i];
          end
          idx_d   = {IDX_W{1'b0}};
          state_d = S_WRITING;
        end else begin
          state_d = S_WAIT_TILE;
        end
      end
      S_WRITING: begin
        // 24-bit add wraps naturally at the top of the address space.
        addr_d = addr_q + 24'd1;
        rem_d  = rem_q - 10'd1;
        idx_d  = idx_q + IDX_W'(1);
        // Remaining count has priority so a partial tile stops early.
        if (rem_q == 10'd1) begin
          state_d = S_DONE;
        end else if (idx_q == IDX_W'(E - 1)) begin
          state_d = S_WAIT_TILE;
        end else begin
          state_d = S_WRITING;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= 24'd0;
      rem_q   <= 10'd0;
      idx_q   <= {IDX_W{1'b0}};
      for (int i = 0; i < E; i++) begin
        buf_q[i] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
      for (int i = 0; i < E; i++) begin
        buf_q[i] <= buf_d[i];
      end
    end
  end

endmodule

// File: tb/tb_store_v.sv
// ---------------------------------------------------------------------------
// tb_store_v
// Self-checking bench for store_v with TILE_WIDTH=32, DATA_WIDTH=8 (E=4).
// Transfers come from a table; expected memory writes are queued when a
// transfer is launched and popped by a monitor as mem_we fires.
// ---------------------------------------------------------------------------
module tb_store_v;

  logic        clk;
  logic        rst;
  logic        valid_in;
  logic [23:0] dram_addr;
  logic [9:0]  length;
  logic [7:0]  tile_in [0:3];
  logic        tile_valid;
  logic        tile_ready;
  logic        mem_we;
  logic [23:0] mem_addr;
  logic [7:0]  mem_din;
  logic        busy;
  logic        valid_out;

  store_v #(.TILE_WIDTH(32), .DATA_WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .valid_in   (valid_in),
    .dram_addr  (dram_addr),
    .length     (length),
    .tile_in    (tile_in),
    .tile_valid (tile_valid),
    .tile_ready (tile_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .busy       (busy),
    .valid_out  (valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [23:0] a;
    logic [7:0]  d;
  } wr_t;

  typedef struct packed {
    logic [23:0] addr;
    logic [9:0]  len;
    logic [3:0]  dly;
    logic        poke;
    logic [95:0] data;   // element k at data[8k +: 8]
  } vec_t;

  wr_t  exp_q [$];
  vec_t vecs [0:5];

  int n_vec = 0;
  int n_err = 0;
  int wr_cnt = 0;
  int hs_cnt = 0;
  int vo_cnt = 0;
  int rdy_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: scoreboard writes and count handshakes / pulses.
  always @(negedge clk) begin
    if (mem_we) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        chk("write while scoreboard empty", exp_q.size(), 1);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("mem_addr", mem_addr, e.a);
        chk("mem_din", mem_din, e.d);
      end
    end
    if (tile_ready) rdy_cnt++;
    if (tile_ready && tile_valid) hs_cnt++;
    if (valid_out) vo_cnt++;
  end

  task automatic clr_counts();
    wr_cnt = 0; hs_cnt = 0; vo_cnt = 0; rdy_cnt = 0;
  endtask

  task automatic push_exp(input logic [23:0] a, input logic [9:0] len, input logic [95:0] data);
    for (int k = 0; k < int'(len); k++) begin
      wr_t w;
      w.a = a + 24'(k);
      w.d = data[8*k +: 8];
      exp_q.push_back(w);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " tile_ready"}, tile_ready, 0);
    chk({tag, " mem_we"}, mem_we, 0);
    chk({tag, " mem_addr"}, mem_addr, 0);
    chk({tag, " mem_din"}, mem_din, 0);
    chk({tag, " valid_out"}, valid_out, 0);
  endtask

  task automatic start(input logic [23:0] a, input logic [9:0] len);
    @(posedge clk); #1;
    valid_in = 1'b1; dram_addr = a; length = len;
    @(posedge clk); #1;
    valid_in = 1'b0; dram_addr = 24'h0; length = 10'd0;
  endtask

  // Offer tile t of data and wait (bounded) until it is taken.
  task automatic give_tile(input int t, input logic [95:0] data);
    int got;
    for (int i = 0; i < 4; i++) tile_in[i] = data[8*(4*t+i) +: 8];
    tile_valid = 1'b1;
    got = 0;
    for (int c = 0; c < 64 && got == 0; c++) begin
      @(negedge clk);
      if (tile_ready) got = 1;
    end
    chk("tile handshake seen", got, 1);
    @(posedge clk); #1;
    tile_valid = 1'b0;
    // Scramble after acceptance; buffered data must not change.
    for (int i = 0; i < 4; i++) tile_in[i] = 8'hEE;
  endtask

  task automatic run_xfer(input vec_t v);
    int ntiles;
    int got;
    ntiles = (int'(v.len) + 3) / 4;
    clr_counts();
    push_exp(v.addr, v.len, v.data);
    start(v.addr, v.len);
    repeat (int'(v.dly)) begin @(posedge clk); #1; end
    for (int t = 0; t < ntiles; t++) begin
      give_tile(t, v.data);
      if (v.poke && t == 0) begin
        valid_in = 1'b1; dram_addr = 24'h000500; length = 10'd3;
        @(posedge clk); #1;
        valid_in = 1'b0; dram_addr = 24'h0; length = 10'd0;
      end
    end
    got = 0;
    for (int c = 0; c < 64 && got == 0; c++) begin
      @(negedge clk);
      if (valid_out) got = 1;
    end
    chk("valid_out seen", got, 1);
    repeat (3) @(negedge clk);
    #1;
    chk("write count", wr_cnt, v.len);
    chk("tile handshakes", hs_cnt, ntiles);
    chk("valid_out pulses", vo_cnt, 1);
    chk("tile_ready cycles", rdy_cnt, ntiles + int'(v.dly));
    chk("scoreboard drained", exp_q.size(), 0);
    chk("busy after done", busy, 0);
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int got;
    vecs[0] = '{addr: 24'h000100, len: 10'd8,  dly: 4'd0, poke: 1'b0,
                data: 96'h00000000_08070605_04030201};
    vecs[1] = '{addr: 24'h000200, len: 10'd6,  dly: 4'd0, poke: 1'b0,
                data: 96'h00000000_B3B2B1B0_A3A2A1A0};
    vecs[2] = '{addr: 24'hFFFFFE, len: 10'd4,  dly: 4'd5, poke: 1'b0,
                data: 96'h00000000_00000000_44332211};
    vecs[3] = '{addr: 24'h000040, len: 10'd10, dly: 4'd0, poke: 1'b1,
                data: 96'hCCCBCAC9_C8C7C6C5_C4C3C2C1};
    vecs[4] = '{addr: 24'h000010, len: 10'd1,  dly: 4'd2, poke: 1'b0,
                data: 96'h00000000_00000000_5A5A5A77};
    vecs[5] = '{addr: 24'h000020, len: 10'd5,  dly: 4'd0, poke: 1'b0,
                data: 96'h00000000_00000019_18171615};

    rst = 1'b1; valid_in = 1'b0; dram_addr = 24'h0; length = 10'd0;
    tile_valid = 1'b0;
    for (int i = 0; i < 4; i++) tile_in[i] = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    for (int v = 0; v < 6; v++) run_xfer(vecs[v]);

    // Zero length: straight to completion, no tile request, no writes.
    clr_counts();
    @(posedge clk); #1;
    valid_in = 1'b1; dram_addr = 24'h000700; length = 10'd0;
    @(negedge clk);
    chk("zero-len valid_out before edge", valid_out, 0);
    @(posedge clk); #1;
    valid_in = 1'b0; dram_addr = 24'h0;
    @(negedge clk);
    chk("zero-len valid_out", valid_out, 1);
    chk("zero-len busy in done", busy, 1);
    chk("zero-len tile_ready", tile_ready, 0);
    @(negedge clk);
    chk("zero-len valid_out drop", valid_out, 0);
    chk("zero-len busy drop", busy, 0);
    #1;
    chk("zero-len writes", wr_cnt, 0);
    chk("zero-len ready cycles", rdy_cnt, 0);
    chk("zero-len pulses", vo_cnt, 1);

    // Reset after the second write of a length-8 transfer.
    clr_counts();
    push_exp(24'h000300, 10'd8, 96'h00000000_88776655_44332211);
    start(24'h000300, 10'd8);
    give_tile(0, 96'h00000000_88776655_44332211);
    got = 0;
    for (int c = 0; c < 64 && got == 0; c++) begin
      @(negedge clk); #1;
      if (wr_cnt >= 2) got = 1;
    end
    chk("second write seen", got, 1);
    rst = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("mid-op reset");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    chk("writes after abort", wr_cnt, 2);
    chk("valid_out after abort", vo_cnt, 0);

    // A clean transfer after the abort.
    run_xfer(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
